result_requant_packer: RTL and testbench
========================================

// Module: result_requant_packer
// PURPOSE
//  Downstream of tinyNPU, upstream of the result RAM writer. Takes 32-bit signed accumulator results,
//  applies optional ReLU, rounding arithmetic right shift and int8 saturation, and packs four int8
//  results little-endian into one 32-bit RAM word with byte enables. Bypass mode (output layer)
//  passes raw 32-bit results. Flush emits a partial last word at end of layer.
// PARAMETERS
//  CNT_W   16   width of emitted-word counter o_word_count
// PORTS
//  i_clk          in   1    clock, all logic on rising edge
//  i_reset        in   1    asynchronous, active-high reset
//  i_relu_en      in   1    1: clamp negative accumulators to 0 before shift
//  i_shift        in   5    requant right-shift amount, 0..31
//  i_bypass       in   1    1: output layer, pass 32-bit raw result, no packing
//  i_data         in   32   signed accumulator from NPU
//  i_valid        in   1    i_data qualifier, single-cycle, may be asserted every cycle
//  i_flush        in   1    single-cycle pulse: end of layer, emit any partial word
//  o_data         out  32   packed word / raw result to RAM writer
//  o_valid        out  1    o_data qualifier, one cycle per word
//  o_byte_en      out  4    lanes valid in o_data (4'hF for full word or bypass)
//  o_flush_done   out  1    one-cycle pulse when flush complete
//  o_word_count   out  CNT_W  words emitted since reset, wraps at 2^CNT_W
// BEHAVIOUR
//  - Reset (async, i_reset=1): o_data=0, o_valid=0, o_byte_en=0, o_flush_done=0, o_word_count=0,
//    lane counter=0, pack register=0, stage-1 valid=0, flush pending=0. Mid-operation reset drops
//    any partial word without emitting it.
//  - No back-pressure: RAM writer accepts every o_valid. Config inputs stable for whole layer;
//    sampled with each sample at stage-1 capture.
//  - Stage 1 (registered, 1 cycle): x=i_data; if i_relu_en and x<0, x=0. If i_shift>0, compute in
//    33 bits: y=(x + (1<<(i_shift-1))) >>> i_shift (round half up); else y=x. Saturate y to [-128,127].
//    In bypass, stage 1 holds raw i_data unchanged.
//  - Stage 2, bypass: o_data=raw, o_byte_en=4'hF, o_valid=1 one cycle after stage 1 => latency 2.
//  - Stage 2, pack: byte written into lane [8*lane+7:8*lane], lane counter 0..3. On 4th byte,
//    word emitted next edge with o_byte_en=4'hF; lane counter wraps to 0, pack reg cleared. First
//    input of a word lands in [7:0]. Latency: 2 cycles from 4th sample's i_valid to o_valid.
//  - FSM: IDLE (lane=0, no pending flush) -> FILL (lane>0) -> back to IDLE on full word;
//    any state -> FLUSH on i_flush; FLUSH waits until stage 1 empty, then if lane>0 emits partial
//    word (unfilled lanes zero, o_byte_en = lanes filled, e.g. 2 lanes -> 4'h3), then pulses
//    o_flush_done, returns IDLE. With lane=0, flush emits nothing, only o_flush_done.
//  - Simultaneous i_valid and i_flush: that sample is included before the flush completes.
//  - i_valid during FLUSH after the flush cycle: protocol violation; sample is dropped.
//  - o_word_count increments on every o_valid (full, partial or bypass); wraps silently.
//  - A full word and o_flush_done never share a cycle; o_flush_done follows the last word by 1 cycle.
// TESTING
//  1 relu=0 shift=0, in 5,-3,127,-128 -> one word 32'h80_7F_FD_05, byte_en F, 2 cycles after 4th valid
//  2 shift=4, in 40 (2.5->3), 39 (2.44->2), -40 (-2.5->-2), 10000 (sat) -> word 32'h7F_FE_02_03
//  3 relu=1 shift=0, in -7,9,-1,0 -> word 32'h00_00_09_00; relu=0 same -> 32'h00_FF_09_F9
//  4 pack, 6 samples 1..6 then i_flush -> word 32'h04030201 F, then 32'h00000605 byte_en 3, then
//    o_flush_done pulse; o_word_count=2
//  5 bypass, back-to-back i_valid 32'h12345678, 32'hFFFFFFFF -> two o_valid cycles, raw data, byte_en F
//  6 2 samples loaded, assert i_reset -> all outputs 0, no word ever emitted; i_flush on empty -> only
//    o_flush_done; count wrap from 16'hFFFF to 0 on next word

Source files
------------

// File: rtl/result_requant_packer_if.sv
`default_nettype none
// ============================================================================
// Module   : result_requant_packer_if
// Brief    : Sample/config input bus and packed-word output bus of the
//            result requantiser/packer.
// Revision : 1.0
// ============================================================================
interface result_requant_packer_if #(
    parameter int CNT_W = 16
);
    logic             i_relu_en;
    logic [4:0]       i_shift;
    logic             i_bypass;
    logic [31:0]      i_data;
    logic             i_valid;
    logic             i_flush;
    logic [31:0]      o_data;
    logic             o_valid;
    logic [3:0]       o_byte_en;
    logic             o_flush_done;
    logic [CNT_W-1:0] o_word_count;

    modport master (
        output i_relu_en, i_shift, i_bypass, i_data, i_valid, i_flush,
        input  o_data, o_valid, o_byte_en, o_flush_done, o_word_count
    );

    modport slave (
        input  i_relu_en, i_shift, i_bypass, i_data, i_valid, i_flush,
        output o_data, o_valid, o_byte_en, o_flush_done, o_word_count
    );
endinterface
`default_nettype wire

// File: rtl/result_requant_packer.sv
`default_nettype none
// ============================================================================
// Module   : result_requant_packer
// Brief    : ReLU / rounding shift / int8 saturation of accumulators, packed
//            four per little-endian 32-bit word; raw bypass and flush.
// Revision : 1.0
// ============================================================================
module result_requant_packer #(
    parameter int CNT_W = 16
) (
    input  wire logic               i_clk,
    input  wire logic               i_reset,
    result_requant_packer_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state, w_state_nx;
    logic              r_s1_valid;
    logic              r_s1_bypass;
    logic [31:0]       r_s1_data;
    logic [1:0]        r_lane, w_lane_nx;
    logic [31:0]       r_pack, w_pack_nx, w_pack_tmp;
    logic [31:0]       r_o_data;
    logic              r_o_valid;
    logic [3:0]        r_o_byte_en;
    logic              r_o_flush_done;
    logic [CNT_W-1:0]  r_word_count;

    logic signed [32:0] w_x, w_sum, w_y;
    logic [7:0]         w_q;
    logic               w_accept;
    logic               w_emit;
    logic [31:0]        w_emit_data;
    logic [3:0]         w_emit_be;
    logic               w_done;

    // Requantise in 33 bits so the rounding offset cannot overflow.
    always_comb begin
        w_x = {bus.i_data[31], bus.i_data};
        if (bus.i_relu_en && bus.i_data[31]) begin
            w_x = '0;
        end
        w_sum = w_x;
        w_y   = w_x;
        if (bus.i_shift != 5'd0) begin
            w_sum = w_x + (33'sd1 <<< (bus.i_shift - 5'd1));
            w_y   = w_sum >>> bus.i_shift;
        end
        if (w_y > 33'sd127) begin
            w_q = 8'h7F;
        end else if (w_y < -33'sd128) begin
            w_q = 8'h80;
        end else begin
            w_q = w_y[7:0];
        end
    end

    // Samples arriving once a flush is under way are dropped.
    assign w_accept = bus.i_valid && (r_state != S_FLUSH) && (r_state != S_DONE);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_s1_valid  <= 1'b0;
            r_s1_bypass <= 1'b0;
            r_s1_data   <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_bypass <= bus.i_bypass;
                r_s1_data   <= bus.i_bypass ? bus.i_data : {24'd0, w_q};
            end
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_lane_nx   = r_lane;
        w_pack_nx   = r_pack;
        w_emit      = 1'b0;
        w_emit_data = r_o_data;
        w_emit_be   = r_o_byte_en;
        w_done      = 1'b0;
        w_pack_tmp  = r_pack | ({24'd0, r_s1_data[7:0]} << {r_lane, 3'b000});

        if (r_s1_valid) begin
            if (r_s1_bypass) begin
                w_emit      = 1'b1;
                w_emit_data = r_s1_data;
                w_emit_be   = 4'hF;
            end else if (r_lane == 2'd3) begin
                w_emit      = 1'b1;
                w_emit_data = w_pack_tmp;
                w_emit_be   = 4'hF;
                w_lane_nx   = 2'd0;
                w_pack_nx   = '0;
            end else begin
                w_lane_nx   = r_lane + 2'd1;
                w_pack_nx   = w_pack_tmp;
            end
        end

        case (r_state)
            S_IDLE, S_FILL: begin
                if (bus.i_flush) begin
                    w_state_nx = S_FLUSH;
                end else begin
                    w_state_nx = (w_lane_nx != 2'd0) ? S_FILL : S_IDLE;
                end
            end
            S_FLUSH: begin
                // Stage 1 is drained first so a coincident sample is included.
                if (!r_s1_valid) begin
                    if (r_lane != 2'd0) begin
                        w_emit      = 1'b1;
                        w_emit_data = r_pack;
                        case (r_lane)
                            2'd1:    w_emit_be = 4'h1;
                            2'd2:    w_emit_be = 4'h3;
                            default: w_emit_be = 4'h7;
                        endcase
                        w_lane_nx  = 2'd0;
                        w_pack_nx  = '0;
                        w_state_nx = S_DONE;
                    end else begin
                        w_done     = 1'b1;
                        w_state_nx = S_IDLE;
                    end
                end
            end
            default: begin
                w_done     = 1'b1;
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state        <= S_IDLE;
            r_lane         <= 2'd0;
            r_pack         <= '0;
            r_o_data       <= '0;
            r_o_valid      <= 1'b0;
            r_o_byte_en    <= 4'h0;
            r_o_flush_done <= 1'b0;
            r_word_count   <= '0;
        end else begin
            r_state        <= w_state_nx;
            r_lane         <= w_lane_nx;
            r_pack         <= w_pack_nx;
            r_o_valid      <= w_emit;
            r_o_flush_done <= w_done;
            if (w_emit) begin
                r_o_data     <= w_emit_data;
                r_o_byte_en  <= w_emit_be;
                r_word_count <= r_word_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign bus.o_data       = r_o_data;
    assign bus.o_valid      = r_o_valid;
    assign bus.o_byte_en    = r_o_byte_en;
    assign bus.o_flush_done = r_o_flush_done;
    assign bus.o_word_count = r_word_count;

endmodule
`default_nettype wire

// File: tb/tb_result_requant_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_result_requant_packer
// Brief    : Self-checking bench for result_requant_packer with a reference
//            model of requantisation and little-endian packing.
// Revision : 1.0
// ============================================================================
module tb_result_requant_packer;

    localparam int CNT_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    logic [35:0] out_q[$];
    int          out_cyc[$];
    int          fd_cyc[$];

    result_requant_packer_if #(.CNT_W(CNT_W)) bus();

    result_requant_packer #(.CNT_W(CNT_W)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.o_valid) begin
            out_q.push_back({bus.o_byte_en, bus.o_data});
            out_cyc.push_back(cyc);
        end
        if (bus.o_flush_done) fd_cyc.push_back(cyc);
    end

    function automatic logic [7:0] ref_q(input logic [31:0] d, input bit relu, input int sh);
        longint v, dv, num, q;
        v = longint'($signed(d));
        if (relu && v < 0) v = 0;
        if (sh == 0) begin
            q = v;
        end else begin
            dv  = longint'(1) << sh;
            num = v + dv / 2;
            q   = num / dv;
            if (num < 0 && (num % dv) != 0) q = q - 1;
        end
        if (q > 127)  q = 127;
        if (q < -128) q = -128;
        return q[7:0];
    endfunction

    task automatic drive(input logic v, input logic [31:0] d, input logic f);
        bus.i_valid = v;
        bus.i_data  = d;
        bus.i_flush = f;
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        bus.i_flush = 1'b0;
    endtask

    task automatic clear_q();
        out_q.delete();
        out_cyc.delete();
        fd_cyc.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0);
        drive(0, 0, 0);
        rst = 1'b0;
        drive(0, 0, 0);
        clear_q();
    endtask

    task automatic wait_flush();
        for (int i = 0; i < 30 && fd_cyc.size() == 0; i++) @(negedge clk);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic set_cfg(input bit relu, input int sh, input bit byp);
        bus.i_relu_en = relu;
        bus.i_shift   = 5'(sh);
        bus.i_bypass  = byp;
    endtask

    task automatic test_reset();
        #2;
        total++;
        if ({bus.o_data, bus.o_valid, bus.o_byte_en, bus.o_flush_done, bus.o_word_count} !== '0) begin
            bad++;
            $display("FAIL reset_state got data=%h v=%b be=%h fd=%b cnt=%0d want all zero",
                     bus.o_data, bus.o_valid, bus.o_byte_en, bus.o_flush_done, bus.o_word_count);
        end
        do_reset();
    endtask

    task automatic test_basic_latency();
        int d[4] = '{5, -3, 127, -128};
        set_cfg(0, 0, 0);
        clear_q();
        for (int i = 0; i < 4; i++) drive(1, 32'(d[i]), 0);
        @(negedge clk);
        total++;
        if (bus.o_valid !== 1'b0) begin
            bad++;
            $display("FAIL latency_early got o_valid=%b want 0", bus.o_valid);
        end
        @(negedge clk);
        total++;
        if ({bus.o_valid, bus.o_byte_en, bus.o_data} !== {1'b1, 4'hF, 32'h807FFD05}) begin
            bad++;
            $display("FAIL basic_word got v=%b be=%h data=%h want v=1 be=f data=807ffd05",
                     bus.o_valid, bus.o_byte_en, bus.o_data);
        end
        total++;
        if (bus.o_word_count !== CNT_W'(1)) begin
            bad++;
            $display("FAIL basic_count got %0d want 1", bus.o_word_count);
        end
        @(negedge clk);
    endtask

    task automatic test_requant();
        int         d[3][4] = '{'{40, 39, -40, 10000}, '{-7, 9, -1, 0}, '{-7, 9, -1, 0}};
        bit         relu[3] = '{0, 1, 0};
        int         sh[3]   = '{4, 0, 0};
        logic [31:0] exp_w[3] = '{32'h7FFE0203, 32'h00000900, 32'h00FF09F9};
        logic [35:0] got;
        for (int r = 0; r < 3; r++) begin
            set_cfg(relu[r], sh[r], 0);
            clear_q();
            for (int i = 0; i < 4; i++) drive(1, 32'(d[r][i]), 0);
            repeat (3) @(negedge clk);
            got = (out_q.size() == 1) ? out_q[0] : 36'hX;
            total++;
            if (got !== {4'hF, exp_w[r]}) begin
                bad++;
                $display("FAIL requant_row%0d got %h (n=%0d) want f%h", r, got, out_q.size(), exp_w[r]);
            end
        end
    endtask

    task automatic test_flush_partial();
        do_reset();
        set_cfg(0, 0, 0);
        for (int i = 1; i <= 6; i++) drive(1, 32'(i), 0);
        drive(0, 0, 1);
        wait_flush();
        total++;
        if (out_q.size() != 2 || out_q[0] !== {4'hF, 32'h04030201} || out_q[1] !== {4'h3, 32'h00000605}) begin
            bad++;
            $display("FAIL flush_words got n=%0d w0=%h w1=%h want f04030201 300000605",
                     out_q.size(), out_q.size() > 0 ? out_q[0] : 36'h0, out_q.size() > 1 ? out_q[1] : 36'h0);
        end
        total++;
        if (fd_cyc.size() != 1 || out_cyc.size() != 2 || fd_cyc[0] != out_cyc[1] + 1) begin
            bad++;
            $display("FAIL flush_done_timing got fd_n=%0d fd_cyc=%0d want one pulse 1 cycle after last word",
                     fd_cyc.size(), fd_cyc.size() > 0 ? fd_cyc[0] : -1);
        end
        total++;
        if (bus.o_word_count !== CNT_W'(2)) begin
            bad++;
            $display("FAIL flush_count got %0d want 2", bus.o_word_count);
        end

        // Sample coincident with flush is included.
        clear_q();
        drive(1, 32'd7, 0);
        drive(1, 32'd8, 1);
        wait_flush();
        total++;
        if (out_q.size() != 1 || out_q[0] !== {4'h3, 32'h00000807} || fd_cyc.size() != 1) begin
            bad++;
            $display("FAIL flush_simul got n=%0d w0=%h fd_n=%0d want 300000807 and one pulse",
                     out_q.size(), out_q.size() > 0 ? out_q[0] : 36'h0, fd_cyc.size());
        end

        // Sample arriving during the flush is dropped and leaves no residue.
        clear_q();
        drive(1, 32'd9, 0);
        drive(0, 0, 1);
        drive(1, 32'd10, 0);
        wait_flush();
        for (int i = 1; i <= 4; i++) drive(1, 32'(i + 16), 0);
        repeat (3) @(negedge clk);
        total++;
        if (out_q.size() != 2 || out_q[0] !== {4'h1, 32'h00000009} || out_q[1] !== {4'hF, 32'h14131211}) begin
            bad++;
            $display("FAIL flush_drop got n=%0d w0=%h w1=%h want 100000009 f14131211",
                     out_q.size(), out_q.size() > 0 ? out_q[0] : 36'h0, out_q.size() > 1 ? out_q[1] : 36'h0);
        end
    endtask

    task automatic test_back_to_back_bypass();
        clear_q();
        set_cfg(0, 3, 1);
        drive(1, 32'h12345678, 0);
        drive(1, 32'hFFFFFFFF, 0);
        repeat (3) @(negedge clk);
        total++;
        if (out_q.size() != 2 || out_q[0] !== {4'hF, 32'h12345678} || out_q[1] !== {4'hF, 32'hFFFFFFFF}
            || out_cyc[1] != out_cyc[0] + 1) begin
            bad++;
            $display("FAIL bypass_b2b got n=%0d w0=%h w1=%h want f12345678 fffffffff back to back",
                     out_q.size(), out_q.size() > 0 ? out_q[0] : 36'h0, out_q.size() > 1 ? out_q[1] : 36'h0);
        end
    endtask

    task automatic test_reset_midway();
        do_reset();
        set_cfg(0, 0, 0);
        drive(1, 32'd1, 0);
        drive(1, 32'd2, 0);
        rst = 1'b1;
        #2;
        total++;
        if ({bus.o_data, bus.o_valid, bus.o_byte_en, bus.o_flush_done, bus.o_word_count} !== '0) begin
            bad++;
            $display("FAIL async_reset got data=%h v=%b be=%h cnt=%0d want all zero",
                     bus.o_data, bus.o_valid, bus.o_byte_en, bus.o_word_count);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_q();
        drive(0, 0, 1);
        wait_flush();
        total++;
        if (out_q.size() != 0 || fd_cyc.size() != 1) begin
            bad++;
            $display("FAIL empty_flush got words=%0d fd_pulses=%0d want 0 and 1", out_q.size(), fd_cyc.size());
        end
    endtask

    task automatic test_count_wrap();
        do_reset();
        set_cfg(0, 0, 1);
        repeat ((1 << CNT_W) - 1) drive(1, $urandom, 0);
        repeat (3) @(negedge clk);
        total++;
        if (bus.o_word_count !== {CNT_W{1'b1}}) begin
            bad++;
            $display("FAIL count_max got %0d want %0d", bus.o_word_count, (1 << CNT_W) - 1);
        end
        drive(1, $urandom, 0);
        repeat (3) @(negedge clk);
        total++;
        if (bus.o_word_count !== '0 || out_q.size() != (1 << CNT_W)) begin
            bad++;
            $display("FAIL count_wrap got cnt=%0d words=%0d want 0 and %0d",
                     bus.o_word_count, out_q.size(), 1 << CNT_W);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 10; it++) begin
            logic [35:0] exp_q[$];
            logic [7:0]  bytes[$];
            logic [31:0] w;
            logic [31:0] d;
            bit  relu, byp, simul;
            int  sh, n, rem;
            do_reset();
            relu  = 1'($urandom_range(0, 1));
            sh    = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 8);
            byp   = ($urandom_range(0, 3) == 0);
            simul = 1'($urandom_range(0, 1));
            n     = $urandom_range(1, 11);
            set_cfg(relu, sh, byp);
            for (int k = 0; k < n; k++) begin
                repeat ($urandom_range(0, 2)) drive(0, 0, 0);
                d = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 4000)) - 32'd2000;
                drive(1, d, (k == n - 1) && simul);
                if (byp) exp_q.push_back({4'hF, d});
                else     bytes.push_back(ref_q(d, relu, sh));
            end
            if (!simul) drive(0, 0, 1);
            for (int b = 0; b + 4 <= bytes.size(); b += 4)
                exp_q.push_back({4'hF, bytes[b+3], bytes[b+2], bytes[b+1], bytes[b]});
            rem = bytes.size() % 4;
            if (rem != 0) begin
                w = '0;
                for (int j = 0; j < rem; j++) w[8*j +: 8] = bytes[bytes.size() - rem + j];
                exp_q.push_back({4'((1 << rem) - 1), w});
            end
            wait_flush();
            total++;
            if (out_q.size() != exp_q.size() || fd_cyc.size() != 1) begin
                bad++;
                $display("FAIL rand%0d_count got words=%0d fd=%0d want words=%0d fd=1",
                         it, out_q.size(), fd_cyc.size(), exp_q.size());
            end else begin
                for (int j = 0; j < exp_q.size(); j++) begin
                    total++;
                    if (out_q[j] !== exp_q[j]) begin
                        bad++;
                        $display("FAIL rand%0d_word%0d got %h want %h (relu=%0d sh=%0d byp=%0d)",
                                 it, j, out_q[j], exp_q[j], relu, sh, byp);
                    end
                end
            end
            total++;
            if (bus.o_word_count !== CNT_W'(exp_q.size())) begin
                bad++;
                $display("FAIL rand%0d_wordcount got %0d want %0d", it, bus.o_word_count, exp_q.size());
            end
        end
    endtask

    initial begin
        bus.i_relu_en = 1'b0;
        bus.i_shift   = 5'd0;
        bus.i_bypass  = 1'b0;
        bus.i_data    = '0;
        bus.i_valid   = 1'b0;
        bus.i_flush   = 1'b0;
        test_reset();
        test_basic_latency();
        test_requant();
        test_flush_partial();
        test_back_to_back_bypass();
        test_reset_midway();
        test_count_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
